// File: rtl/dcm_prog_pkg.sv
// Shared constants for the DCM_CLKGEN programming-port responder.
package dcm_prog_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    SHIFT = 3'd2,
    TAIL  = 3'd3,
    LOCK  = 3'd4
  } state_t;

  localparam logic CMD_LOAD = 1'b1;
  localparam logic SEL_D    = 1'b0;
  localparam logic SEL_M    = 1'b1;

  localparam int PROG_FIELD_BITS = 8;
endpackage

// File: rtl/dcm_prog_shift8.sv
// 8-bit LSB-first field shifter with bit count; o_done is high once a full field is held.
module dcm_prog_shift8
  import dcm_prog_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_shift,
  input  logic                       i_bit,
  output logic [PROG_FIELD_BITS-1:0] o_dat,
  output logic [3:0]                 o_cnt,
  output logic                       o_done
);
  logic [PROG_FIELD_BITS-1:0] r_dat;
  logic [3:0]                 r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_dat <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_dat <= {i_bit, r_dat[PROG_FIELD_BITS-1:1]};
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_dat  = r_dat;
  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == 4'(PROG_FIELD_BITS));
endmodule

// File: rtl/dcm_prog_responder.sv
// Responder for the DCM_CLKGEN PROGEN/PROGDATA/PROGDONE port: decodes LoadD/LoadM/GO,
// commits M-1/D-1 on GO and holds PROGDONE low for LOCK_CYCLES before signalling relock.
module dcm_prog_responder
  import dcm_prog_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [7:0]  INIT_D_M1   = 8'd9,
  parameter logic [7:0]  INIT_M_M1   = 8'd59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_en,
  input  logic       prog_data,
  output logic       prog_done,
  output logic [7:0] d_m1,
  output logic [7:0] m_m1,
  output logic       cfg_valid,
  output logic       prog_err
);
  state_t      r_state;
  logic        r_go;
  logic        r_sel;
  logic [7:0]  r_pend_d;
  logic [7:0]  r_pend_m;
  logic        r_pend_d_vld;
  logic        r_pend_m_vld;
  logic [15:0] r_cnt;
  logic        r_prog_done;
  logic [7:0]  r_d_m1;
  logic [7:0]  r_m_m1;
  logic        r_cfg_valid;
  logic        r_prog_err;

  logic        w_clr;
  logic        w_shift;
  logic        w_last;
  logic        w_done;
  logic [7:0]  w_shadow;
  logic [3:0]  w_bit_cnt;

  assign w_clr   = (r_state == CMD) && prog_en;
  assign w_shift = (r_state == SHIFT) && prog_en;
  assign w_last  = w_shift && (w_bit_cnt == 4'(PROG_FIELD_BITS - 1));

  dcm_prog_shift8 u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_bit   (prog_data),
    .o_dat   (w_shadow),
    .o_cnt   (w_bit_cnt),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_go         <= 1'b0;
      r_sel        <= SEL_D;
      r_pend_d     <= '0;
      r_pend_m     <= '0;
      r_pend_d_vld <= 1'b0;
      r_pend_m_vld <= 1'b0;
      r_cnt        <= '0;
      r_prog_done  <= 1'b1;
      r_d_m1       <= INIT_D_M1;
      r_m_m1       <= INIT_M_M1;
      r_cfg_valid  <= 1'b0;
      r_prog_err   <= 1'b0;
    end else begin
      r_cfg_valid <= 1'b0;
      r_prog_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (prog_en) begin
            if (prog_data == CMD_LOAD) begin
              r_go    <= 1'b0;
              r_state <= CMD;
            end else begin
              r_go    <= 1'b1;
              r_state <= TAIL;
            end
          end
        end
        CMD: begin
          if (prog_en) begin
            r_sel   <= prog_data;
            r_state <= SHIFT;
          end else begin
            r_prog_err <= 1'b1;
            r_state    <= IDLE;
          end
        end
        SHIFT: begin
          if (!prog_en) begin
            r_prog_err <= 1'b1;
            r_state    <= IDLE;
          end else if (w_last) begin
            r_state <= TAIL;
          end
        end
        TAIL: begin
          r_go <= 1'b0;
          if (prog_en) begin
            r_prog_err <= 1'b1;
            r_state    <= IDLE;
          end else if (r_go) begin
            if (r_pend_d_vld) r_d_m1 <= r_pend_d;
            if (r_pend_m_vld) r_m_m1 <= r_pend_m;
            r_pend_d_vld <= 1'b0;
            r_pend_m_vld <= 1'b0;
            r_prog_done  <= 1'b0;
            r_cnt        <= 16'(LOCK_CYCLES);
            r_state      <= LOCK;
          end else begin
            if (w_done) begin
              if (r_sel == SEL_D) begin
                r_pend_d     <= w_shadow;
                r_pend_d_vld <= 1'b1;
              end else begin
                r_pend_m     <= w_shadow;
                r_pend_m_vld <= 1'b1;
              end
            end
            r_state <= IDLE;
          end
        end
        LOCK: begin
          r_cnt <= r_cnt - 16'd1;
          // On the final lock cycle cfg_valid takes precedence so the two pulses never coincide.
          if (r_cnt == 16'd1) begin
            r_prog_done <= 1'b1;
            r_cfg_valid <= 1'b1;
            r_state     <= IDLE;
          end else if (prog_en) begin
            r_prog_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prog_done = r_prog_done;
  assign d_m1      = r_d_m1;
  assign m_m1      = r_m_m1;
  assign cfg_valid = r_cfg_valid;
  assign prog_err  = r_prog_err;
endmodule

// File: doc/dcm_prog_responder.md
Name: dcm_prog_responder

Overview:
- Synthesizable responder for the DCM_CLKGEN serial programming port (PROGEN/PROGDATA/PROGDONE).
- Decodes LoadD, LoadM and GO sequences as issued by the dcm_controller programmer.
- Drives PROGDONE with a programmable relock delay and exposes the committed M-1/D-1 values.
- Stands in for the DCM in simulation and emulation builds, and serves as a protocol checker on the prog port.

Parameters:
- LOCK_CYCLES, 16, number of clk cycles prog_done stays low after GO; legal range 1..65535.
- INIT_D_M1, 8'd9, committed D-1 value after reset.
- INIT_M_M1, 8'd59, committed M-1 value after reset.

Ports:
- clk  input  1  programming clock; the same clock that drives the programmer.
- rst_n  input  1  asynchronous active-low reset.
- prog_en  input  1  PROGEN from the programmer.
- prog_data  input  1  PROGDATA from the programmer.
- prog_done  output  1  PROGDONE to the programmer.
- d_m1  output  8  committed divider minus 1.
- m_m1  output  8  committed multiplier minus 1.
- cfg_valid  output  1  one-cycle pulse when relock completes.
- prog_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All state is updated on the rising edge of clk.
- Reset values:
  - prog_done = 1; d_m1 = INIT_D_M1; m_m1 = INIT_M_M1; cfg_valid = 0; prog_err = 0.
  - Pending D/M flags cleared; FSM in IDLE; lock counter = 0.
- Inputs are sampled directly, with no synchronizer, because they come from the same clock.
- FSM states: IDLE, CMD, SHIFT, TAIL, LOCK.
- IDLE:
  - prog_en=0: stay.
  - prog_en=1, prog_data=1: go to CMD (load command).
  - prog_en=1, prog_data=0: GO candidate; latch go_flag and go to TAIL.
- CMD:
  - Requires prog_en=1. Latch sel = prog_data (0 = LoadD, 1 = LoadM), clear the bit counter, go to SHIFT.
  - prog_en=0: prog_err pulse, return to IDLE.
- SHIFT:
  - Each cycle requires prog_en=1. prog_data is shifted LSB-first into an 8-bit shadow register (shadow <= {prog_data, shadow[7:1]}).
  - After the 8th bit, go to TAIL.
  - prog_en=0 mid-shift: prog_err pulse, shadow discarded, IDLE.
- TAIL:
  - Requires prog_en=0.
  - If go_flag is set: commit pending D and M values (unpending fields keep their committed value), clear the pending flags, drive prog_done=0 on the next cycle, load the counter with LOCK_CYCLES, go to LOCK.
  - Otherwise: write shadow to pend_d or pend_m according to sel, set its pending flag, go to IDLE.
  - prog_en=1 in TAIL: prog_err pulse, nothing written, IDLE.
- LOCK:
  - prog_done=0. The counter decrements each cycle.
  - At counter==1: the next cycle has prog_done=1 and cfg_valid=1 (single-cycle pulse), and the FSM goes to IDLE.
  - prog_en=1 during LOCK: prog_err pulse. The lock sequence continues and the input is ignored.
- Commit timing: d_m1/m_m1 update on the cycle prog_done falls (GO acknowledged), not at cfg_valid.
- GO with no pending loads is legal: committed values are unchanged, but the relock sequence still runs.
- LoadD/LoadM repeated before GO: last write wins.
- prog_err and cfg_valid never pulse in the same cycle.
- Reset mid-sequence: everything returns to reset values immediately; prog_done goes high asynchronously.
- Programmer compatibility: the programmer's 3-cycle and 2-cycle PROGEN-low gaps are accepted. Any gap of at least 1 cycle is legal, since IDLE absorbs the extra cycles.

Decomposition:
- Shared package dcm_prog_pkg holds:
  - the state enum constants (IDLE=0, CMD=1, SHIFT=2, TAIL=3, LOCK=4);
  - the command-bit constants (CMD_LOAD=1'b1, SEL_D=1'b0, SEL_M=1'b1);
  - the bit-count constant PROG_FIELD_BITS=8.
- One sub-module is natural: dcm_prog_shift8, an 8-bit LSB-first shifter with count/done output. The FSM, pending registers and lock counter stay in the top module.

Test Plan:
- Full programmer sequence: 1,0, then 0x09 LSB-first, en low 3 cycles, then 1,1, then 0x3B LSB-first, en low 2 cycles, then GO (en=1, d=0) and en low → d_m1=0x09 and m_m1=0x3B on the prog_done fall; prog_done low for exactly 16 cycles; one cfg_valid pulse.
- LoadM 0x57 only, then GO → m_m1=0x57, d_m1 unchanged at 0x09; relock of 16 cycles.
- prog_en dropped after 5 LoadD bits → prog_err pulse, d_m1 unchanged; a following valid LoadD 0x03 plus GO commits d_m1=0x03.
- prog_en held high for a 9th bit after LoadM → prog_err pulse, no pending write; a later GO leaves m_m1 unchanged.
- prog_en pulsed during LOCK → prog_err pulse; prog_done still returns high after 16 cycles with cfg_valid.
- rst_n asserted during LOCK (cycle 7) → prog_done=1 immediately; d_m1=9 and m_m1=59 restored; no cfg_valid pulse.
